// File: rtl/rtl_kernel_ctrl_multi.sv
// Kernel ap_ctrl sequencer: fans ap_start out to N channel engines, gathers masked
// per-channel done, supports hs/chain handshakes and aborts a run on a cycle timeout.
module rtl_kernel_ctrl_multi #(
  parameter int C_NUM_CHANNELS  = 4,
  parameter int C_MODE_CHAIN    = 0,
  parameter int C_TIMEOUT_WIDTH = 32
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       ap_start,
  input  logic                       ap_continue,
  output logic                       ap_idle,
  output logic                       ap_done,
  output logic                       ap_ready,
  input  logic [C_NUM_CHANNELS-1:0]  chan_enable,
  input  logic [C_TIMEOUT_WIDTH-1:0] timeout_cycles,
  output logic [C_NUM_CHANNELS-1:0]  chan_start,
  input  logic [C_NUM_CHANNELS-1:0]  chan_done,
  output logic [C_NUM_CHANNELS-1:0]  chan_done_seen,
  output logic                       timeout_err,
  output logic [C_TIMEOUT_WIDTH-1:0] cycle_count
);

  localparam int N = C_NUM_CHANNELS;
  localparam int W = C_TIMEOUT_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     rst_sync;
  logic           rst_int_n;
  logic           start_r;
  logic           empty_pend;
  logic [N-1:0]   mask;
  logic [W-1:0]   tmo;
  logic           start_pulse;
  logic [N-1:0]   done_now;
  logic [N-1:0]   seen_nxt;
  logic           complete;
  logic           tmo_hit;
  logic           cont_ok;
  logic           accept;
  logic           finish;
  logic           fire_empty;
  logic           release_done;

  // Reset asserts asynchronously but leaves reset in step with ap_clk.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign start_pulse = ap_start & ~start_r;
  assign done_now    = chan_done & mask;
  assign seen_nxt    = chan_done_seen | done_now;
  assign complete    = (seen_nxt == mask);
  assign tmo_hit     = (tmo != '0) && (cycle_count == tmo - 1'b1) && !complete;
  assign cont_ok     = (C_MODE_CHAIN == 0) || ap_continue;
  assign ap_idle     = (state != S_RUN);

  always_ff @(posedge ap_clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    finish       = 1'b0;
    fire_empty   = 1'b0;
    release_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_pulse) begin
          accept    = 1'b1;
          state_nxt = (chan_enable == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (complete || tmo_hit) begin
          finish    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // An empty run spends one DONE cycle before raising ap_done.
        if (empty_pend) begin
          fire_empty = 1'b1;
        end else if (cont_ok) begin
          release_done = 1'b1;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      start_r        <= 1'b0;
      chan_start     <= '0;
      chan_done_seen <= '0;
      timeout_err    <= 1'b0;
      cycle_count    <= '0;
      ap_done        <= 1'b0;
      ap_ready       <= 1'b0;
      empty_pend     <= 1'b0;
    end else begin
      start_r    <= ap_start;
      chan_start <= accept ? chan_enable : '0;
      ap_ready   <= finish | fire_empty;
      if (finish || fire_empty) ap_done <= 1'b1;
      else if (release_done)    ap_done <= 1'b0;
      if (accept) begin
        chan_done_seen <= '0;
        timeout_err    <= 1'b0;
        cycle_count    <= '0;
        empty_pend     <= (chan_enable == '0);
      end
      if (state == S_DONE) empty_pend <= 1'b0;
      if (state == S_RUN) begin
        chan_done_seen <= seen_nxt;
        // The exit cycle is not counted, so a timeout leaves cycle_count at tmo-1.
        if (!finish && (cycle_count != '1)) cycle_count <= cycle_count + 1'b1;
        if (tmo_hit) timeout_err <= 1'b1;
      end
    end
  end

  // Run parameters are captured at acceptance and need no reset value.
  always_ff @(posedge ap_clk) begin
    if (accept) begin
      mask <= chan_enable;
      tmo  <= timeout_cycles;
    end
  end

endmodule

// File: tb/tb_rtl_kernel_ctrl_multi.sv
// Directed bench for rtl_kernel_ctrl_multi: one hs-mode and one chain-mode instance share inputs.
module tb_rtl_kernel_ctrl_multi;

  localparam int N = 4;
  localparam int W = 32;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         ap_start = 1'b0;
  logic         ap_continue = 1'b1;
  logic [N-1:0] chan_enable = '0;
  logic [N-1:0] chan_done = '0;
  logic [W-1:0] timeout_cycles = '0;

  logic         idle_hs, done_hs, ready_hs, terr_hs;
  logic [N-1:0] cstart_hs, seen_hs;
  logic [W-1:0] cnt_hs;
  logic         idle_ch, done_ch, ready_ch, terr_ch;
  logic [N-1:0] cstart_ch, seen_ch;
  logic [W-1:0] cnt_ch;

  int n_vec = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  rtl_kernel_ctrl_multi #(.C_NUM_CHANNELS(N), .C_MODE_CHAIN(0), .C_TIMEOUT_WIDTH(W)) dut_hs (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_idle(idle_hs), .ap_done(done_hs), .ap_ready(ready_hs),
    .chan_enable(chan_enable), .timeout_cycles(timeout_cycles),
    .chan_start(cstart_hs), .chan_done(chan_done), .chan_done_seen(seen_hs),
    .timeout_err(terr_hs), .cycle_count(cnt_hs)
  );

  rtl_kernel_ctrl_multi #(.C_NUM_CHANNELS(N), .C_MODE_CHAIN(1), .C_TIMEOUT_WIDTH(W)) dut_ch (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_idle(idle_ch), .ap_done(done_ch), .ap_ready(ready_ch),
    .chan_enable(chan_enable), .timeout_cycles(timeout_cycles),
    .chan_start(cstart_ch), .chan_done(chan_done), .chan_done_seen(seen_ch),
    .timeout_err(terr_ch), .cycle_count(cnt_ch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n  = 1'b0;
    ap_start  = 1'b0;
    chan_done = '0;
    tick();
    tick();
    ap_rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic start_run(input logic [N-1:0] en, input logic [W-1:0] tmo);
    chan_enable    = en;
    timeout_cycles = tmo;
    ap_start       = 1'b1;
    tick();
    ap_start = 1'b0;
  endtask

  initial begin
    int bad;
    int dhigh;
    int rdy;

    // Reset values
    do_reset();
    chk("rst_idle",   32'(idle_hs),   1);
    chk("rst_done",   32'(done_hs),   0);
    chk("rst_ready",  32'(ready_hs),  0);
    chk("rst_cstart", 32'(cstart_hs), 0);
    chk("rst_seen",   32'(seen_hs),   0);
    chk("rst_terr",   32'(terr_hs),   0);
    chk("rst_cnt",    cnt_hs,         0);

    // 1: all channels, staggered done at cycles 5, 9, 12, 20
    start_run(4'b1111, 0);
    chk("t1_cstart", 32'(cstart_hs), 'hF);
    chk("t1_busy",   32'(idle_hs),   0);
    bad = 0;
    for (int c = 1; c <= 20; c++) begin
      chan_done = (c == 5) ? 4'b0001 : (c == 9) ? 4'b0010 : (c == 12) ? 4'b0100 :
                  (c == 20) ? 4'b1000 : 4'b0000;
      if (done_hs) bad++;
      tick();
      if (c == 1) chk("t1_cstart_pulse", 32'(cstart_hs), 0);
    end
    chan_done = '0;
    chk("t1_early_done", 32'(bad), 0);
    chk("t1_done",  32'(done_hs),  1);
    chk("t1_ready", 32'(ready_hs), 1);
    chk("t1_seen",  32'(seen_hs),  'hF);
    chk("t1_terr",  32'(terr_hs),  0);
    chk("t1_idle",  32'(idle_hs),  1);
    tick();
    chk("t1_done_off",  32'(done_hs),  0);
    chk("t1_ready_off", 32'(ready_hs), 0);

    // 2: sparse mask, disabled channels ignored
    do_reset();
    start_run(4'b0101, 0);
    chk("t2_cstart", 32'(cstart_hs), 'h5);
    chan_done = 4'b1010;
    tick();
    tick();
    chk("t2_seen_dis", 32'(seen_hs), 0);
    chk("t2_done_dis", 32'(done_hs), 0);
    chan_done = 4'b0001;
    tick();
    chk("t2_seen_ch0", 32'(seen_hs), 'h1);
    chk("t2_done_ch0", 32'(done_hs), 0);
    chan_done = 4'b0100;
    tick();
    chan_done = '0;
    chk("t2_done", 32'(done_hs), 1);
    chk("t2_seen", 32'(seen_hs), 'h5);
    tick();

    // 3: timeout after 10 RUN cycles, then completion exactly in cycle 10
    do_reset();
    start_run(4'b0011, 10);
    chan_done = 4'b0001;
    tick();
    chan_done = '0;
    repeat (8) tick();
    chk("t3_not_yet", 32'(done_hs), 0);
    chk("t3_cnt_run", cnt_hs,       9);
    tick();
    chk("t3_done", 32'(done_hs), 1);
    chk("t3_terr", 32'(terr_hs), 1);
    chk("t3_cnt",  cnt_hs,       9);
    chk("t3_seen", 32'(seen_hs), 'h1);
    tick();
    start_run(4'b0011, 10);
    chk("t3b_terr_clr", 32'(terr_hs), 0);
    chan_done = 4'b0001;
    tick();
    chan_done = '0;
    repeat (8) tick();
    chan_done = 4'b0010;
    tick();
    chan_done = '0;
    chk("t3b_done", 32'(done_hs), 1);
    chk("t3b_terr", 32'(terr_hs), 0);
    chk("t3b_seen", 32'(seen_hs), 'h3);
    tick();

    // 4: chain mode holds ap_done until ap_continue
    do_reset();
    ap_continue = 1'b0;
    start_run(4'b0001, 0);
    chk("t4_cstart", 32'(cstart_ch), 'h1);
    chan_done = 4'b0001;
    tick();
    chan_done = '0;
    chk("t4_done",  32'(done_ch),  1);
    chk("t4_ready", 32'(ready_ch), 1);
    dhigh = 1;
    rdy   = 1;
    bad   = 0;
    for (int i = 1; i <= 7; i++) begin
      if (i == 3) ap_start = 1'b1;
      if (i == 4) ap_start = 1'b0;
      tick();
      dhigh += int'(done_ch);
      rdy   += int'(ready_ch);
      if (cstart_ch != '0) bad++;
    end
    chk("t4_done_held",  32'(dhigh), 8);
    chk("t4_ready_once", 32'(rdy),   1);
    chk("t4_start_drop", 32'(bad),   0);
    chk("t4_idle_wait",  32'(idle_ch), 1);
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    chk("t4_done_rel", 32'(done_ch), 0);
    tick();
    tick();
    chk("t4_no_queue", 32'(cstart_ch), 0);
    chk("t4_idle",     32'(idle_ch),   1);
    ap_continue = 1'b1;
    start_run(4'b0001, 0);
    chk("t4b_cstart", 32'(cstart_ch), 'h1);
    chan_done = 4'b0001;
    tick();
    chan_done = '0;
    chk("t4b_done", 32'(done_ch), 1);
    tick();
    chk("t4b_done_rel", 32'(done_ch), 0);

    // 5: empty run, ap_start held high
    do_reset();
    chan_enable = '0;
    ap_start    = 1'b1;
    tick();
    chk("t5_done_e0", 32'(done_hs),   0);
    chk("t5_cstart",  32'(cstart_hs), 0);
    chk("t5_idle",    32'(idle_hs),   1);
    tick();
    chk("t5_done",  32'(done_hs),  1);
    chk("t5_ready", 32'(ready_hs), 1);
    tick();
    chk("t5_done_off", 32'(done_hs), 0);
    chan_enable = 4'b1111;
    bad = 0;
    repeat (5) begin
      tick();
      if (done_hs || (cstart_hs != '0) || !idle_hs) bad++;
    end
    chk("t5_no_rerun", 32'(bad), 0);
    ap_start = 1'b0;

    // 6: reset in the middle of a run
    do_reset();
    start_run(4'b1111, 0);
    chan_done = 4'b0011;
    tick();
    chan_done = '0;
    tick();
    chk("t6_seen_pre", 32'(seen_hs), 'h3);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("t6_idle",   32'(idle_hs),   1);
    chk("t6_seen",   32'(seen_hs),   0);
    chk("t6_cnt",    cnt_hs,         0);
    chk("t6_done",   32'(done_hs),   0);
    tick();
    tick();
    ap_rst_n = 1'b1;
    repeat (3) tick();
    start_run(4'b1111, 0);
    chk("t6_cstart", 32'(cstart_hs), 'hF);
    chan_done = 4'b1111;
    tick();
    chan_done = '0;
    chk("t6_done_new", 32'(done_hs), 1);
    chk("t6_seen_new", 32'(seen_hs), 'hF);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
